// File: rtl/step_sequencer.sv
// One-hot micro-step generator for the IAS control unit: programmable cycle length,
// stall, synchronous restart, start/halt run control and a completed-cycle counter.
module step_sequencer #(
    parameter  int NUM_STEPS = 7,
    parameter  int CNT_W     = 16,
    localparam int IDX_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_halt_req,
    input  logic                 i_en,
    input  logic                 i_clr,
    input  logic [IDX_W-1:0]     i_last_step,
    output logic [NUM_STEPS-1:0] o_steps,
    output logic [IDX_W-1:0]     o_step_idx,
    output logic                 o_busy,
    output logic                 o_cycle_end,
    output logic [CNT_W-1:0]     o_cycle_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_MAX = IDX_W'(NUM_STEPS - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_step_idx;
    logic             r_halt_pend;
    logic [CNT_W-1:0] r_cycle_cnt;

    logic [IDX_W-1:0] w_eff_last;
    logic             w_at_last;
    logic             w_halt;

    // last_step can exceed the step table when IDX_W rounds up; clamp it.
    assign w_eff_last = (i_last_step > LAST_MAX) ? LAST_MAX : i_last_step;
    assign w_at_last  = (r_step_idx >= w_eff_last);
    assign w_halt     = r_halt_pend | i_halt_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_step_idx  <= '0;
            r_halt_pend <= 1'b0;
            r_cycle_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (i_start) begin
                        r_state     <= S_RUN;
                        r_step_idx  <= '0;
                        r_halt_pend <= i_halt_req;
                    end
                end
                S_RUN: begin
                    if (i_clr) begin
                        r_step_idx  <= '0;
                        r_halt_pend <= w_halt;
                    end else if (!i_en) begin
                        r_halt_pend <= w_halt;
                    end else if (w_at_last) begin
                        r_step_idx  <= '0;
                        r_cycle_cnt <= r_cycle_cnt + 1'b1;
                        // A pending halt is only honoured at the cycle boundary.
                        if (w_halt) begin
                            r_state     <= S_HALT;
                            r_halt_pend <= 1'b0;
                        end
                    end else begin
                        r_step_idx  <= r_step_idx + 1'b1;
                        r_halt_pend <= w_halt;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_step_idx <= '0;
                end
            endcase
        end
    end

    assign o_busy      = (r_state == S_RUN);
    assign o_step_idx  = r_step_idx;
    assign o_steps     = o_busy ? (NUM_STEPS'(1) << r_step_idx) : '0;
    assign o_cycle_end = o_busy & i_en & w_at_last;
    assign o_cycle_cnt = r_cycle_cnt;

endmodule
